// File: rtl/toubi_pkg.sv
// Shared encodings and constants for the coin-payment / change stage.
// State encoding, default prices, coin values and the coin-sum helper live here.
package toubi_pkg;

  localparam int AMT_W_DEF  = 8;
  localparam int PRICE0_DEF = 2;
  localparam int PRICE1_DEF = 3;
  localparam int PRICE2_DEF = 4;
  localparam int PRICE3_DEF = 5;

  localparam logic [4:0] COIN1_VAL  = 5'd1;
  localparam logic [4:0] COIN5_VAL  = 5'd5;
  localparam logic [4:0] COIN10_VAL = 5'd10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAY      = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  // Value of all coin pulses arriving in one cycle (max 16).
  function automatic logic [4:0] coin_sum(input logic c1, input logic c5, input logic c10);
    logic [4:0] s;
    s = 5'd0;
    if (c1) begin
      s = s + COIN1_VAL;
    end
    if (c5) begin
      s = s + COIN5_VAL;
    end
    if (c10) begin
      s = s + COIN10_VAL;
    end
    return s;
  endfunction

endpackage

// File: rtl/zhaoling.sv
// Greedy change ejector: one 5-yuan or 1-yuan pulse per step, empty pulse when nothing is left.
// A step taken together with load acts on the freshly loaded value in the same edge.
module zhaoling
  import toubi_pkg::*;
#(
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [AMT_W-1:0] i_value,
  output logic             o_y5,
  output logic             o_y1,
  output logic             o_empty
);

  localparam logic [AMT_W-1:0] FIVE = AMT_W'(COIN5_VAL);
  localparam logic [AMT_W-1:0] ONE  = AMT_W'(COIN1_VAL);

  logic [AMT_W-1:0] r_rem;
  logic             r_y5;
  logic             r_y1;
  logic             r_empty;
  logic [AMT_W-1:0] w_src;

  // Select the remainder the next action works on
  always_comb begin
    w_src = r_rem;
    if (i_load) begin
      w_src = i_value;
    end else begin
      w_src = r_rem;
    end
  end

  // Remainder register and registered ejection pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem   <= '0;
      r_y5    <= 1'b0;
      r_y1    <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_y5    <= 1'b0;
      r_y1    <= 1'b0;
      r_empty <= 1'b0;
      if (i_step) begin
        if (w_src >= FIVE) begin
          r_y5  <= 1'b1;
          r_rem <= w_src - FIVE;
        end else if (w_src >= ONE) begin
          r_y1  <= 1'b1;
          r_rem <= w_src - ONE;
        end else begin
          r_empty <= 1'b1;
          r_rem   <= '0;
        end
      end else if (i_load) begin
        r_rem <= i_value;
      end else begin
        r_rem <= r_rem;
      end
    end
  end

  assign o_y5    = r_y5;
  assign o_y1    = r_y1;
  assign o_empty = r_empty;

endmodule

// File: rtl/toubi_zhaoling.sv
// Coin-payment stage ahead of the ticket dispenser: latches the order, accumulates coins,
// drives the dispenser enable and then hands the remainder to the change ejector.
module toubi_zhaoling
  import toubi_pkg::*;
#(
  parameter int AMT_W     = AMT_W_DEF,
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 1000,
  parameter int PRICE0    = PRICE0_DEF,
  parameter int PRICE1    = PRICE1_DEF,
  parameter int PRICE2    = PRICE2_DEF,
  parameter int PRICE3    = PRICE3_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_sel_ticket,
  input  logic [1:0]       i_sel_count,
  input  logic             i_coin1,
  input  logic             i_coin5,
  input  logic             i_coin10,
  input  logic             i_cancel,
  output logic             o_en,
  output logic [1:0]       o_ticket,
  output logic [1:0]       o_count,
  output logic [AMT_W-1:0] o_cost,
  output logic [AMT_W-1:0] o_paid,
  output logic             o_out_y5,
  output logic             o_out_y1,
  output logic             o_coin_rej,
  output logic             o_busy,
  output logic             o_done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(EN_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] EN_LAST = EW'(EN_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ticket;
  logic [1:0]       r_count;
  logic [AMT_W-1:0] r_cost;
  logic [AMT_W-1:0] r_paid;
  logic [TW-1:0]    r_timer;
  logic [EW-1:0]    r_en_cnt;
  logic             r_en;
  logic             r_coin_rej;
  logic             r_busy;

  logic [4:0]       w_sum;
  logic [AMT_W:0]   w_total;
  logic             w_ovf;
  logic             w_accept;
  logic             w_any_coin;
  logic [AMT_W-1:0] w_new_paid;
  logic [3:0]       w_unit;
  logic [3:0]       w_cost4;
  logic             w_timeout;
  logic             w_zl_load;
  logic             w_zl_step;
  logic [AMT_W-1:0] w_zl_value;
  logic             w_y5;
  logic             w_y1;
  logic             w_empty;

  assign w_sum      = coin_sum(i_coin1, i_coin5, i_coin10);
  assign w_total    = {1'b0, r_paid} + (AMT_W + 1)'(w_sum);
  assign w_ovf      = w_total[AMT_W];
  assign w_accept   = (w_sum != 5'd0) && !w_ovf;
  assign w_any_coin = i_coin1 | i_coin5 | i_coin10;
  assign w_new_paid = w_accept ? w_total[AMT_W-1:0] : r_paid;
  assign w_timeout  = !w_accept && (r_timer == TO_LAST);
  assign w_cost4    = w_unit * {2'b00, i_sel_count};

  // Unit price lookup for the selected ticket type
  always_comb begin
    w_unit = 4'd0;
    case (i_sel_ticket)
      2'd0:    w_unit = 4'(PRICE0);
      2'd1:    w_unit = 4'(PRICE1);
      2'd2:    w_unit = 4'(PRICE2);
      2'd3:    w_unit = 4'(PRICE3);
      default: w_unit = 4'd0;
    endcase
  end

  // Next-state decode and change-ejector control
  always_comb begin
    w_state_nxt = r_state;
    w_zl_load   = 1'b0;
    w_zl_step   = 1'b0;
    w_zl_value  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start && (i_sel_count != 2'd0)) begin
          w_state_nxt = S_PAY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PAY: begin
        // Refund paths load and take the first change action on the same edge
        if (i_cancel) begin
          w_state_nxt = S_CHANGE;
          w_zl_load   = 1'b1;
          w_zl_step   = 1'b1;
          w_zl_value  = w_new_paid;
        end else if (w_timeout) begin
          w_state_nxt = S_CHANGE;
          w_zl_load   = 1'b1;
          w_zl_step   = 1'b1;
          w_zl_value  = r_paid;
        end else if (w_new_paid >= r_cost) begin
          w_state_nxt = S_DISPENSE;
          w_zl_load   = 1'b1;
          w_zl_value  = w_new_paid - r_cost;
        end else begin
          w_state_nxt = S_PAY;
        end
      end
      S_DISPENSE: begin
        if (r_en_cnt == EN_LAST) begin
          w_state_nxt = S_CHANGE;
          w_zl_step   = 1'b1;
        end else begin
          w_state_nxt = S_DISPENSE;
        end
      end
      S_CHANGE: begin
        if (w_empty) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CHANGE;
          w_zl_step   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, order latches, accumulator, timers and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ticket   <= 2'd0;
      r_count    <= 2'd0;
      r_cost     <= '0;
      r_paid     <= '0;
      r_timer    <= '0;
      r_en_cnt   <= '0;
      r_en       <= 1'b0;
      r_coin_rej <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_coin_rej <= w_any_coin && ((r_state != S_PAY) || w_ovf);
      case (r_state)
        S_IDLE: begin
          if (i_start && (i_sel_count != 2'd0)) begin
            r_ticket <= i_sel_ticket;
            r_count  <= i_sel_count;
            r_cost   <= AMT_W'(w_cost4);
            r_paid   <= '0;
            r_timer  <= '0;
          end
        end
        S_PAY: begin
          r_paid <= w_new_paid;
          if (w_accept) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
          if (w_state_nxt == S_DISPENSE) begin
            r_en     <= 1'b1;
            r_en_cnt <= '0;
          end
        end
        S_DISPENSE: begin
          if (r_en_cnt == EN_LAST) begin
            r_en <= 1'b0;
          end else begin
            r_en_cnt <= r_en_cnt + EW'(1);
          end
        end
        default: begin
          r_en <= 1'b0;
        end
      endcase
    end
  end

  zhaoling #(
    .AMT_W(AMT_W)
  ) u_zhaoling (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_zl_load),
    .i_step (w_zl_step),
    .i_value(w_zl_value),
    .o_y5   (w_y5),
    .o_y1   (w_y1),
    .o_empty(w_empty)
  );

  assign o_en       = r_en;
  assign o_ticket   = r_ticket;
  assign o_count    = r_count;
  assign o_cost     = r_cost;
  assign o_paid     = r_paid;
  assign o_out_y5   = w_y5;
  assign o_out_y1   = w_y1;
  assign o_coin_rej = r_coin_rej;
  assign o_busy     = r_busy;
  assign o_done     = w_empty;

endmodule

// File: doc/toubi_zhaoling.md
Name: toubi_zhaoling

Overview:
- Coin-payment and change stage sitting directly upstream of the ticket dispenser (chupiao).
- Latches the passenger's ticket type and count, and computes the cost.
- Accumulates inserted coins. When paid ≥ cost, it drives the dispenser's en/ticket/count inputs.
- Then pays out change greedily in 5-yuan and 1-yuan coins. Supports cancel/refund and inactivity timeout.

Parameters:
- AMT_W, 8, width of paid/change accumulators (yuan).
- EN_CYCLES, 2, number of cycles en is held high toward the dispenser (≥1).
- TIMEOUT, 1000, idle cycles in PAY before automatic refund (≥1).
- PRICE0..PRICE3, 2/3/4/5, unit price in yuan for ticket codes 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  1-cycle pulse: latch sel_ticket/sel_count (IDLE only).
- sel_ticket  in  2  ticket type code.
- sel_count  in  2  number of tickets, 1..3; 0 is invalid.
- coin1, coin5, coin10  in  1 each  1-cycle coin-accept pulses; may coincide.
- cancel  in  1  1-cycle refund request.
- en  out  1  dispense enable to chupiao.
- ticket  out  2  latched ticket type to chupiao.
- count  out  2  latched count to chupiao.
- cost  out  AMT_W  latched price×count.
- paid  out  AMT_W  running coin total.
- out_y5, out_y1  out  1 each  change coin-ejection pulses.
- coin_rej  out  1  registered pulse: an inserted coin was returned.
- busy  out  1  state ≠ IDLE.
- done  out  1  1-cycle pulse at end of transaction.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE. All outputs 0. Internal remainder and timeout counter 0. Reset mid-transaction abandons the transaction with no refund pulses.
- States: IDLE, PAY, DISPENSE, CHANGE.
- IDLE:
  - start with sel_count≠0: latch ticket/count, set cost = PRICE[sel_ticket]×sel_count (max 15), clear paid, enter PAY next cycle.
  - start with sel_count=0: ignored.
  - Coins in IDLE: not accepted; coin_rej=1 on the next cycle.
- PAY:
  - sum = 1·coin1 + 5·coin5 + 10·coin10, and paid ← paid+sum next cycle.
  - If paid+sum would exceed 2^AMT_W−1, the whole cycle's coins are rejected (coin_rej next cycle, paid unchanged).
  - Any accepted coin resets the timeout counter. Otherwise the counter increments.
  - Priority: cancel → CHANGE with remainder=paid+sum (refund, en never asserted). Else timeout reached → CHANGE with remainder=paid. Else paid+sum ≥ cost → DISPENSE with remainder = paid+sum−cost. Else stay in PAY.
  - The transition occurs on the same edge that updates paid.
- DISPENSE:
  - en=1 for exactly EN_CYCLES consecutive cycles, with ticket/count stable throughout.
  - Then → CHANGE.
  - Coins and cancel are ignored; coins are rejected via coin_rej.
- CHANGE: one action per cycle.
  - remainder ≥ 5: out_y5=1, remainder −= 5.
  - else remainder ≥ 1: out_y1=1, remainder −= 1.
  - else (remainder=0): done=1, → IDLE.
  - Change 0 means done in the first CHANGE cycle.
  - Coins are rejected.
- Boundaries:
  - paid exactly equal to cost gives zero change.
  - Overpayment by a single 10-yuan coin is allowed.
  - cost and paid hold their values after done until the next start.
  - en is never high in the same cycle as out_y5 or out_y1.

Decomposition:
- Package toubi_pkg holds: the state encoding (IDLE/PAY/DISPENSE/CHANGE), the PRICE constants, coin value constants (1/5/10), and the AMT_W default.
- Sub-module zhaoling (greedy change ejector) takes load/value and produces out_y5/out_y1 pulses plus an empty flag.
- The FSM and accumulator remain in the top module.

Test Plan:
- start ticket=2, count=3 (cost 12), then coin10, coin5 → paid 15, en high 2 cycles with ticket=2/count=3, then out_y1 ×3, then done.
- start ticket=3, count=2 (cost 10), then coin5, coin5 → en 2 cycles, no change pulses, done in the first CHANGE cycle.
- start ticket=0, count=1 (cost 2), then coin10 → en, then out_y5 ×1 followed by out_y1 ×3, then done; total change 8.
- start ticket=1, count=1, then coin1, then cancel together with coin5 → en never high, refund 6 = out_y5 ×1 + out_y1 ×1, then done.
- start with count=0 → busy stays 0. Coin5 in IDLE → coin_rej pulse, paid unchanged.
- Timeout and reset case: start ticket=1, count=3, coin5, then TIMEOUT idle cycles → refund out_y5 ×1, then done. Separately, assert rst during DISPENSE → en=0 and state IDLE on the next edge.
